store_lane_packer: RTL

//  Inverse of immediate/load extension: narrows 32-bit store data from the MEM stage into

---
 rtl/store_lane_packer.sv | 118 +++++++++++
 1 files changed

// File: rtl/store_lane_packer.sv
// Store-side lane packer: replicates sb/sh/sw data across byte lanes, builds byte
// enables, and queues packed stores for data memory; misaligned stores raise an error pulse.
module store_lane_packer #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_mode,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [31:0]              in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [31:0]              out_data,
    output logic [3:0]               out_be,
    output logic                     err_valid,
    output logic [ADDR_W-1:0]        err_addr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [3:0]        be_q   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_valid_q;
    logic [ADDR_W-1:0] err_addr_q;

    logic        legal, accept, push, pop;
    logic [31:0] pack_data;
    logic [3:0]  pack_be;

    always_comb begin
        legal     = 1'b0;
        pack_data = in_data;
        pack_be   = 4'b1111;
        case (in_mode)
            2'b01: begin
                legal     = 1'b1;
                pack_data = {4{in_data[7:0]}};
                pack_be   = 4'b0001 << in_addr[1:0];
            end
            2'b10: begin
                legal     = ~in_addr[0];
                pack_data = {2{in_data[15:0]}};
                pack_be   = in_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b11: legal = (in_addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign accept    = in_valid & in_ready;
    // Flush drops the push and pop of its cycle, but illegal stores still report.
    assign push      = accept & legal & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        count_d = count_q;
        if (flush)
            count_d = '0;
        else if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            count_q     <= count_d;
            err_valid_q <= accept & ~legal;
            if (accept && !legal)
                err_addr_q <= in_addr;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    addr_q[wr_ptr_q] <= {in_addr[ADDR_W-1:2], 2'b00};
                    data_q[wr_ptr_q] <= pack_data;
                    be_q[wr_ptr_q]   <= pack_be;
                    wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
                end
                if (pop)
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Head fields read as zero while the buffer is empty.
    assign out_addr  = out_valid ? addr_q[rd_ptr_q] : '0;
    assign out_data  = out_valid ? data_q[rd_ptr_q] : '0;
    assign out_be    = out_valid ? be_q[rd_ptr_q]   : '0;
    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
    assign count     = count_q;

endmodule
